// File: rtl/tc_to_signmag_serial.sv
// Bit-serial 32-bit two's-complement to sign-magnitude converter, LSB first, valid/ready on both sides.
// Optional macro TC2SM_EARLY_EXIT_EN: non-negative operands bypass the serial pass and finish in one cycle.
module tc_to_signmag_serial (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_sign,
  output logic [31:0] out_mag,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] src_q, src_d;
  logic [31:0] res_q, res_d;
  logic        sign_q, sign_d;
  logic        seen_q, seen_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        cur_bit;
  logic        res_bit;

  // Copy bits up to and including the first one, invert everything above it (negatives only).
  assign cur_bit = src_q[cnt_q];
  assign res_bit = (sign_q & seen_q) ? ~cur_bit : cur_bit;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      src_q   <= '0;
      res_q   <= '0;
      sign_q  <= 1'b0;
      seen_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      res_q   <= res_d;
      sign_q  <= sign_d;
      seen_q  <= seen_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    res_d   = res_q;
    sign_d  = sign_q;
    seen_d  = seen_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          src_d  = in_data;
          sign_d = in_data[31];
          seen_d = 1'b0;
          cnt_d  = '0;
          res_d  = '0;
`ifdef TC2SM_EARLY_EXIT_EN
          if (!in_data[31]) begin
            res_d   = in_data;
            state_d = ST_DONE;
          end else begin
            state_d = ST_SHIFT;
          end
`else
          state_d = ST_SHIFT;
`endif
        end
      end
      ST_SHIFT: begin
        res_d  = {res_bit, res_q[31:1]};
        seen_d = seen_q | cur_bit;
        cnt_d  = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are gated so a half-built magnitude never leaks out of the block.
  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign out_sign  = (state_q == ST_DONE) & sign_q;
  assign out_mag   = (state_q == ST_DONE) ? res_q : '0;

endmodule

// File: tb/tb_tc_to_signmag_serial.sv
// Self-checking bench for tc_to_signmag_serial: transaction-level model checked every cycle plus directed literals.
// Latency expectations follow TC2SM_EARLY_EXIT_EN when defined.
module tb_tc_to_signmag_serial;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        out_ready = 1'b0;
  logic        in_ready;
  logic        out_valid;
  logic        out_sign;
  logic [31:0] out_mag;
  logic        busy;

  int errors = 0;
  int checks = 0;
  bit mon_on = 1'b0;

  // Transaction model: busy flag, cycles left until the result shows, expected {sign, mag}.
  bit          m_busy = 1'b0;
  int          m_wait = 0;
  logic [32:0] m_exp = '0;
  int          n_acc = 0;
  int          n_xfer = 0;

`ifdef TC2SM_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  always #5 clk = ~clk;

  tc_to_signmag_serial dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sign  (out_sign),
    .out_mag   (out_mag),
    .busy      (busy)
  );

  function automatic logic [32:0] tc2sm(input logic [31:0] a);
    logic [31:0] mag;
    mag = a[31] ? (~a + 32'd1) : a;
    return {a[31], mag};
  endfunction

  function automatic int lat_of(input logic [31:0] a);
    return (EARLY && !a[31]) ? 1 : 32;
  endfunction

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Compare process: outputs after each rising edge are checked at the following falling edge.
  task automatic monitor_loop();
    forever begin
      @(negedge clk);
      if (!mon_on) begin
        m_busy = 1'b0;
        m_wait = 0;
      end else begin
        check1("in_ready", in_ready, !m_busy);
        check1("busy", busy, m_busy);
        check1("out_valid", out_valid, m_busy && (m_wait == 0));
        if (m_busy && (m_wait == 0)) begin
          check1("out_sign", out_sign, m_exp[32]);
          check32("out_mag", out_mag, m_exp[31:0]);
        end
        if (!rst_n) begin
          m_busy = 1'b0;
          m_wait = 0;
        end else if (!m_busy) begin
          if (in_valid) begin
            m_busy = 1'b1;
            m_wait = lat_of(in_data);
            m_exp  = tc2sm(in_data);
            n_acc++;
          end
        end else if (m_wait > 0) begin
          m_wait--;
        end else if (out_ready) begin
          m_busy = 1'b0;
          n_xfer++;
          $display("txn %0d: sign=%0d mag=%h", n_xfer, out_sign, out_mag);
        end
      end
    end
  endtask

  task automatic watchdog();
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: cycle budget exhausted, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check1("in_ready_wait", in_ready, 1'b1);
  endtask

  task automatic send(input logic [31:0] a);
    wait_ready();
    in_valid = 1'b1;
    in_data  = a;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = $urandom;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic run_one(input logic [31:0] a, input logic es, input logic [31:0] em);
    int n;
    out_ready = 1'b1;
    send(a);
    wait_valid(n);
    check32("latency", n, lat_of(a));
    check1("lit_valid", out_valid, 1'b1);
    check1("lit_sign", out_sign, es);
    check32("lit_mag", out_mag, em);
    @(posedge clk); #1;
    check1("post_in_ready", in_ready, 1'b1);
    check1("post_out_valid", out_valid, 1'b0);
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] tbl [5];
    tbl[0] = 32'h0000_0000;
    tbl[1] = 32'h8000_0000;
    tbl[2] = 32'hFFFF_FFFF;
    tbl[3] = 32'h7FFF_FFFF;
    tbl[4] = 32'h0000_0001;
    if ($urandom_range(0, 7) == 0) return tbl[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  initial begin
    int n;
    int x0;
    int a0;
    int sent;
    int cyc;
    fork
      monitor_loop();
      watchdog();
    join_none

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check1("rst_in_ready", in_ready, 1'b1);
    check1("rst_out_valid", out_valid, 1'b0);
    check1("rst_out_sign", out_sign, 1'b0);
    check32("rst_out_mag", out_mag, 32'h0);
    check1("rst_busy", busy, 1'b0);
    rst_n  = 1'b1;
    mon_on = 1'b1;

    // Directed values with hand-computed results
    run_one(32'hFFFF_FFFB, 1'b1, 32'h0000_0005);
    run_one(32'h8000_0000, 1'b1, 32'h8000_0000);
    run_one(32'h0000_0000, 1'b0, 32'h0000_0000);
    run_one(32'h7FFF_FFFF, 1'b0, 32'h7FFF_FFFF);
    run_one(32'h0000_0001, 1'b0, 32'h0000_0001);
    run_one(32'hFFFF_FF00, 1'b1, 32'h0000_0100);

    // Backpressure with ignored in_valid pulses during SHIFT and DONE
    x0 = n_xfer;
    out_ready = 1'b0;
    send(32'hFFFF_FFF9);
    in_valid = 1'b1;
    in_data  = 32'h1234_5678;
    wait_valid(n);
    check32("bp_latency", n, 32);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      in_data = $urandom;
      check1("bp_valid", out_valid, 1'b1);
      check1("bp_in_ready", in_ready, 1'b0);
      check1("bp_sign", out_sign, 1'b1);
      check32("bp_mag", out_mag, 32'h0000_0007);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check1("bp_done_valid", out_valid, 1'b0);
    check1("bp_done_ready", in_ready, 1'b1);
    check32("bp_xfers", n_xfer - x0, 1);

    // Reset in the middle of a -1 conversion
    x0 = n_xfer;
    send(32'hFFFF_FFFF);
    repeat (14) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check1("mid_rst_in_ready", in_ready, 1'b1);
    check1("mid_rst_out_valid", out_valid, 1'b0);
    check32("mid_rst_out_mag", out_mag, 32'h0);
    check1("mid_rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    check32("mid_rst_xfers", n_xfer - x0, 0);
    run_one(32'hFFFF_FFFF, 1'b1, 32'h0000_0001);

    // Random operands with random out_ready
    x0 = n_xfer;
    a0 = n_acc;
    sent = 0;
    cyc = 0;
    while ((sent < 1000 || (n_xfer - x0) < 1000) && cyc < 80000) begin
      out_ready = ($urandom_range(0, 1) == 1);
      if (sent < 1000 && in_ready && $urandom_range(0, 3) != 0) begin
        in_valid = 1'b1;
        in_data  = pick();
        sent++;
      end else begin
        in_valid = !in_ready && ($urandom_range(0, 3) == 0);
        in_data  = $urandom;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check32("rand_accepts", n_acc - a0, 1000);
    check32("rand_xfers", n_xfer - x0, 1000);

    repeat (2) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tc_to_signmag_serial.md
# tc_to_signmag_serial

Bit-serial converter from 32-bit two's-complement to sign-magnitude form. It is the decode counterpart of the combinational two's-complement negator in the miniRISC datapath. It sits beside the ALU and feeds a sign flag plus an unsigned magnitude to the multi-cycle multiply/divide sequencer and the debug display path. One operand is processed per transaction, LSB first, over 32 cycles, using the copy-up-to-first-one-then-invert rule, with valid/ready handshakes on both sides.

## Interface
No parameters; width is fixed at 32.
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous, active-low reset, sampled on clk rising edge
- in_valid  input  1  in_data holds an operand
- in_ready  output  1  block can accept an operand (high only in IDLE)
- in_data  input  32  two's-complement operand
- out_valid  output  1  out_sign/out_mag hold a result
- out_ready  input  1  consumer accepts the result
- out_sign  output  1  1 = negative operand
- out_mag  output  32  unsigned magnitude |in_data|
- busy  output  1  high in SHIFT or DONE

## Operation
- States: IDLE, SHIFT, DONE. in_ready = (state==IDLE). out_valid = (state==DONE). busy = (state!=IDLE).
- IDLE, accept (in_valid & in_ready): latch src = in_data, sign = in_data[31], seen_one = 0, cnt = 0, clear result register, go to SHIFT.
- SHIFT, one bit per cycle with b = src[cnt]:
  - res_bit = (sign & seen_one) ? ~b : b.
  - Shift res_bit into result MSB, shifting right.
  - seen_one |= b; cnt++.
  - After processing cnt==31, go to DONE.
- DONE: out_mag = result, out_sign = sign, both stable until transfer. On out_valid & out_ready, go to IDLE.
- Arithmetic rules:
  - out_mag is 32-bit unsigned, so -2^31 gives sign 1, mag 0x8000_0000, with no overflow.
  - Zero gives sign 0, mag 0. A negative zero is never produced.
- in_valid is ignored outside IDLE. in_data is sampled only at the accept edge and may change afterwards.
- Reset at any cycle, mid-SHIFT included, aborts the transaction. No partial result is ever presented.

## Timing
- Reset values: state IDLE, in_ready 1, out_valid 0, out_sign 0, out_mag 0, busy 0.
- Accept at edge T. Bits are processed on edges T+1..T+32, and out_valid rises after edge T+32. Latency is 32 cycles from accept to out_valid.
- out_ready may already be high when out_valid rises. The transfer happens at the first edge with both high, so the earliest is T+33, and in_ready returns after that edge.
- No overlap: a new accept cannot occur in the same cycle as a result transfer. Maximum throughput is one operand per 34 cycles.
- Backpressure: out_valid, out_sign and out_mag hold unchanged for as long as out_ready stays low.

## Configuration
- Macro: TC2SM_EARLY_EXIT_EN.
- Defined:
  - An accepted operand with in_data[31]==0 goes straight from IDLE to DONE with out_mag = in_data, out_sign = 0. out_valid rises after edge T+1.
  - Negative operands still take 32 cycles.
- Undefined: every operand takes the full 32-cycle SHIFT path, giving deterministic latency.
- Results are identical either way; only the cycle counts differ.

## Test plan
- Reset, then in_data=0xFFFF_FFFB (-5) accepted at T, out_ready=1 → out_valid at T+32, sign 1, mag 0x0000_0005; in_ready high after T+33.
- in_data=0x8000_0000 → sign 1, mag 0x8000_0000.
- in_data=0x0000_0000 and then 0x7FFF_FFFF → sign 0, mags 0 and 0x7FFF_FFFF. Latency is 32 without the macro and 1 with TC2SM_EARLY_EXIT_EN.
- Hold out_ready=0 for 10 cycles after out_valid → outputs stable; in_valid pulses during SHIFT/DONE are ignored (in_ready=0); a single transfer occurs on out_ready.
- Assert rst_n=0 at T+15 of a -1 conversion → next cycle IDLE, in_ready 1, out_valid 0, out_mag 0. A fresh 0xFFFF_FFFF then yields sign 1, mag 1.
- 1000 random operands with a random out_ready pattern → each result matches the model {a[31], a[31] ? (~a+1) : a}; no drops or duplicates.
